// File: rtl/trackball_quad_decoder.sv
// Trackball direction/clock receiver: synchronises and deglitches h/v lines,
// counts filtered clock rising edges per axis and serves latched snapshots to the CPU.
module trackball_quad_decoder #(
  parameter int FILTER = 4,
  parameter int WIDTH  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             h_dir,
  input  logic             h_clk,
  input  logic             v_dir,
  input  logic             v_clk,
  input  logic             flip,
  input  logic             latch,
  input  logic             addr,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] h_count,
  output logic [WIDTH-1:0] v_count
);

  localparam logic [3:0]       FILT_LAST = 4'(FILTER - 1);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  // Line order inside the 4-bit vectors: 0 = h_dir, 1 = h_clk, 2 = v_dir, 3 = v_clk.
  logic [3:0]       w_in;
  logic [3:0]       w_accept;
  logic             w_hEvent;
  logic             w_vEvent;
  logic             w_hUp;
  logic             w_vUp;

  logic [3:0]       r_s1;
  logic [3:0]       r_s2;
  logic [3:0]       r_filt;
  logic [3:0]       r_fcnt [4];
  logic [WIDTH-1:0] r_hCount;
  logic [WIDTH-1:0] r_vCount;
  logic [WIDTH-1:0] r_holdH;
  logic [WIDTH-1:0] r_holdV;
  logic [WIDTH-1:0] r_dout;

  assign w_in = {v_clk, v_dir, h_clk, h_dir};

  always_comb begin
    w_accept = '0;
    for (int l = 0; l < 4; l++) begin
      w_accept[l] = (r_s2[l] != r_filt[l]) && (r_fcnt[l] == FILT_LAST);
    end
  end

  // A count fires on the same edge the filtered clock line is accepted high.
  assign w_hEvent = w_accept[1] & r_s2[1];
  assign w_vEvent = w_accept[3] & r_s2[3];
  assign w_hUp    = r_filt[0] ^ flip;
  assign w_vUp    = r_filt[2] ^ flip;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_filt <= '0;
      for (int l = 0; l < 4; l++) begin
        r_fcnt[l] <= '0;
      end
    end else begin
      r_s1 <= w_in;
      r_s2 <= r_s1;
      for (int l = 0; l < 4; l++) begin
        if (r_s2[l] == r_filt[l]) begin
          r_fcnt[l] <= '0;
        end else if (w_accept[l]) begin
          r_filt[l] <= r_s2[l];
          r_fcnt[l] <= '0;
        end else begin
          r_fcnt[l] <= r_fcnt[l] + 4'd1;
        end
      end
    end
  end

  // Hold registers sample the pre-update counters, so a same-edge count shows up in the next latch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hCount <= '0;
      r_vCount <= '0;
      r_holdH  <= '0;
      r_holdV  <= '0;
      r_dout   <= '0;
    end else begin
      if (w_hEvent) begin
        r_hCount <= w_hUp ? r_hCount + ONE : r_hCount - ONE;
      end
      if (w_vEvent) begin
        r_vCount <= w_vUp ? r_vCount + ONE : r_vCount - ONE;
      end
      if (latch) begin
        r_holdH <= r_hCount;
        r_holdV <= r_vCount;
      end
      r_dout <= addr ? r_holdV : r_holdH;
    end
  end

  assign h_count = r_hCount;
  assign v_count = r_vCount;
  assign dout    = r_dout;

endmodule

// File: tb/tb_trackball_quad_decoder.sv
// Bench for trackball_quad_decoder: directed scenarios plus random line activity,
// all checked against a sample-window reference model.
module tb_trackball_quad_decoder;

  localparam int FILTER = 4;
  localparam int WIDTH  = 8;

  logic             clk;
  logic             reset_n;
  logic             h_dir;
  logic             h_clk;
  logic             v_dir;
  logic             v_clk;
  logic             flip;
  logic             latch;
  logic             addr;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] h_count;
  logic [WIDTH-1:0] v_count;

  int total = 0;
  int bad   = 0;
  bit checkEn = 0;

  trackball_quad_decoder #(.FILTER(FILTER), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .h_dir   (h_dir),
    .h_clk   (h_clk),
    .v_dir   (v_dir),
    .v_clk   (v_clk),
    .flip    (flip),
    .latch   (latch),
    .addr    (addr),
    .dout    (dout),
    .h_count (h_count),
    .v_count (v_count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a line is accepted at a new level once the last FILTER
  // synchronised samples all disagree with the current accepted level.
  bit               mHist [4][FILTER+1];
  bit               mFilt [4];
  bit               mNew  [4];
  bit               mOk;
  logic [WIDTH-1:0] mH, mV, mHoldH, mHoldV, mDout;
  logic [3:0]       mIn;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int l = 0; l < 4; l++) begin
        mFilt[l] = 0;
        for (int i = 0; i <= FILTER; i++) mHist[l][i] = 0;
      end
      mH = 0; mV = 0; mHoldH = 0; mHoldV = 0; mDout = 0;
    end else begin
      mIn = {v_clk, v_dir, h_clk, h_dir};
      for (int l = 0; l < 4; l++) begin
        mOk = 1;
        for (int i = 1; i <= FILTER; i++) if (mHist[l][i] == mFilt[l]) mOk = 0;
        mNew[l] = mOk ? ~mFilt[l] : mFilt[l];
      end
      mDout = addr ? mHoldV : mHoldH;
      if (latch) begin
        mHoldH = mH;
        mHoldV = mV;
      end
      if (!mFilt[1] && mNew[1]) mH = ((mFilt[0] ^ flip) != 0) ? mH + 8'd1 : mH - 8'd1;
      if (!mFilt[3] && mNew[3]) mV = ((mFilt[2] ^ flip) != 0) ? mV + 8'd1 : mV - 8'd1;
      for (int l = 0; l < 4; l++) begin
        mFilt[l] = mNew[l];
        for (int i = FILTER; i > 0; i--) mHist[l][i] = mHist[l][i-1];
        mHist[l][0] = mIn[l];
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn && reset_n) begin
      checkOutput("model h_count", 32'(h_count), 32'(mH));
      checkOutput("model v_count", 32'(v_count), 32'(mV));
      checkOutput("model dout", 32'(dout), 32'(mDout));
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input bit doH, input bit doV, input int cycles);
    if (doH) h_clk = 1;
    if (doV) v_clk = 1;
    waitCycles(cycles);
    if (doH) h_clk = 0;
    if (doV) v_clk = 0;
    waitCycles(cycles);
  endtask

  task automatic doReset;
    @(negedge clk);
    reset_n = 0;
    waitCycles(2);
    reset_n = 1;
    waitCycles(2);
  endtask

  initial begin
    reset_n = 0;
    h_dir = 0; h_clk = 0; v_dir = 0; v_clk = 0;
    flip = 0; latch = 0; addr = 0;
    waitCycles(3);
    checkOutput("reset h_count", 32'(h_count), 32'h0);
    checkOutput("reset v_count", 32'(v_count), 32'h0);
    checkOutput("reset dout", 32'(dout), 32'h0);
    reset_n = 1;
    checkEn = 1;

    // Three clean pulses, then latch and read H.
    h_dir = 1;
    waitCycles(20);
    for (int p = 0; p < 3; p++) applyStimulus(1, 0, 20);
    checkOutput("three pulses h", 32'(h_count), 32'h03);
    checkOutput("three pulses v", 32'(v_count), 32'h00);
    latch = 1;
    addr  = 0;
    waitCycles(1);
    latch = 0;
    waitCycles(1);
    checkOutput("latched h read", 32'(dout), 32'h03);

    // Glitch rejection and exact acceptance latency.
    h_clk = 1;
    waitCycles(3);
    h_clk = 0;
    waitCycles(20);
    checkOutput("short glitch", 32'(h_count), 32'h03);
    h_clk = 1;
    waitCycles(4);
    h_clk = 0;
    waitCycles(1);
    checkOutput("latency edge+4", 32'(h_count), 32'h03);
    waitCycles(1);
    checkOutput("latency edge+5", 32'(h_count), 32'h04);
    waitCycles(20);

    // Wrap both ways on V.
    doReset();
    v_dir = 0;
    h_dir = 0;
    waitCycles(10);
    applyStimulus(0, 1, 10);
    checkOutput("v wrap down", 32'(v_count), 32'hFF);
    v_dir = 1;
    waitCycles(10);
    applyStimulus(0, 1, 10);
    applyStimulus(0, 1, 10);
    checkOutput("v wrap up", 32'(v_count), 32'h01);

    // Flip inverts direction; simultaneous H/V events.
    doReset();
    flip  = 1;
    h_dir = 1;
    v_dir = 0;
    waitCycles(10);
    applyStimulus(1, 0, 10);
    applyStimulus(1, 0, 10);
    checkOutput("flip h", 32'(h_count), 32'hFE);
    flip  = 0;
    v_dir = 1;
    waitCycles(10);
    h_clk = 1;
    v_clk = 1;
    waitCycles(5);
    checkOutput("simul pre h", 32'(h_count), 32'hFE);
    checkOutput("simul pre v", 32'(v_count), 32'h00);
    waitCycles(1);
    checkOutput("simul post h", 32'(h_count), 32'hFF);
    checkOutput("simul post v", 32'(v_count), 32'h01);
    h_clk = 0;
    v_clk = 0;
    waitCycles(10);

    // Latch on the same edge as a count.
    doReset();
    h_dir = 1;
    waitCycles(10);
    for (int p = 0; p < 16; p++) applyStimulus(1, 0, 6);
    checkOutput("reach 0x10", 32'(h_count), 32'h10);
    addr  = 0;
    h_clk = 1;
    waitCycles(5);
    latch = 1;
    waitCycles(1);
    latch = 0;
    checkOutput("same-edge count", 32'(h_count), 32'h11);
    waitCycles(1);
    checkOutput("same-edge hold", 32'(dout), 32'h10);
    latch = 1;
    waitCycles(1);
    latch = 0;
    waitCycles(1);
    checkOutput("next latch hold", 32'(dout), 32'h11);
    addr = 1;
    waitCycles(1);
    checkOutput("addr v hold", 32'(dout), 32'h00);
    h_clk = 0;
    waitCycles(10);

    // Asynchronous reset in the middle of filtering.
    addr  = 0;
    h_clk = 1;
    waitCycles(2);
    @(posedge clk);
    #2;
    reset_n = 0;
    h_clk   = 0;
    #1;
    checkOutput("async rst h", 32'(h_count), 32'h0);
    checkOutput("async rst v", 32'(v_count), 32'h0);
    checkOutput("async rst dout", 32'(dout), 32'h0);
    @(negedge clk);
    reset_n = 1;
    waitCycles(10);
    checkOutput("pending dropped", 32'(h_count), 32'h0);
    applyStimulus(1, 0, 8);
    applyStimulus(1, 0, 8);
    checkOutput("count from zero", 32'(h_count), 32'h02);

    // Random line activity, glitches included.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) h_clk = ~h_clk;
      if ($urandom_range(7) == 0) v_clk = ~v_clk;
      if ($urandom_range(39) == 0) h_dir = ~h_dir;
      if ($urandom_range(39) == 0) v_dir = ~v_dir;
      if ($urandom_range(199) == 0) flip = ~flip;
      latch = ($urandom_range(7) == 0);
      addr  = 1'($urandom_range(1));
    end
    waitCycles(2);
    checkEn = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
